// File: rtl/slope_peak_detector_if.sv
// Sample-in / peak-and-BPM-out bundle for slope_peak_detector.
// master = sample producer, slave = detector.
interface slope_peak_detector_if #(
    parameter int unsigned DATA_W = 10
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic              peak_pulse;
    logic              peak_led;
    logic [7:0]        bpm;
    logic              bpm_valid;
    logic [7:0]        slope_dbg;

    modport master (
        output sample_valid, sample,
        input  peak_pulse, peak_led, bpm, bpm_valid, slope_dbg
    );

    modport slave (
        input  sample_valid, sample,
        output peak_pulse, peak_led, bpm, bpm_valid, slope_dbg
    );
endinterface

// File: rtl/slope_peak_detector.sv
// Slope-window peak detector with refractory blanking and a sample-count BPM window.
// All outputs come straight from registers.
module slope_peak_detector #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned WIN      = 32,
    parameter int unsigned RISE_MIN = 22,
    parameter int unsigned FALL_MIN = 18,
    parameter int unsigned REFRACT  = 64,
    parameter int unsigned BEAT_WIN = 10000,
    parameter int unsigned BPM_MULT = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    slope_peak_detector_if.slave bus
);
    localparam int unsigned HW = 2 * WIN;
    localparam int unsigned CW = $clog2(WIN + 1);
    localparam int unsigned SW = $clog2(HW + 1);
    localparam int unsigned RW = $clog2(REFRACT + 1);
    localparam int unsigned WW = $clog2(BEAT_WIN + 1);
    localparam int unsigned PW = 40;

    logic [HW-1:0]     r_s;
    logic [DATA_W-1:0] r_prev;
    logic              r_loaded;
    logic [SW-1:0]     r_shift_cnt;
    logic [CW-1:0]     r_rise_old;
    logic [CW-1:0]     r_fall_new;
    logic [RW-1:0]     r_refr;
    logic [7:0]        r_beats;
    logic [WW-1:0]     r_wcnt;
    logic              r_peak;
    logic [7:0]        r_bpm;
    logic              r_bpm_valid;

    logic              w_accept;
    logic              w_shift;
    logic              w_bit;
    logic [CW-1:0]     w_rise_nxt;
    logic [CW-1:0]     w_fall_nxt;
    logic [SW-1:0]     w_cnt_nxt;
    logic              w_primed_nxt;
    logic              w_detect;
    logic [7:0]        w_beats_fin;
    logic              w_close;
    logic [PW-1:0]     w_prod;
    logic [7:0]        w_bpm_sat;
    logic [HW+7:0]     w_s_ext;

    assign w_accept = bus.sample_valid;
    assign w_shift  = w_accept & r_loaded;
    assign w_bit    = bus.sample > r_prev;

    // s[WIN-1] crosses from the newer into the older half; s[HW-1] falls off the end
    assign w_rise_nxt = r_rise_old + CW'(r_s[WIN-1]) - CW'(r_s[HW-1]);
    assign w_fall_nxt = r_fall_new + CW'(!w_bit) - CW'(!r_s[WIN-1]);

    assign w_cnt_nxt    = (r_shift_cnt == SW'(HW)) ? r_shift_cnt : r_shift_cnt + SW'(1);
    assign w_primed_nxt = (w_cnt_nxt == SW'(HW));

    assign w_detect = w_shift && w_primed_nxt
                   && (w_rise_nxt >= CW'(RISE_MIN))
                   && (w_fall_nxt >= CW'(FALL_MIN))
                   && (r_refr == '0);

    assign w_beats_fin = (w_detect && (r_beats != 8'hff)) ? r_beats + 8'd1 : r_beats;
    assign w_close     = w_accept && (r_wcnt == WW'(BEAT_WIN - 1));
    assign w_prod      = PW'(w_beats_fin) * PW'(BPM_MULT);
    assign w_bpm_sat   = (w_prod > PW'(255)) ? 8'hff : w_prod[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s         <= '0;
            r_prev      <= '0;
            r_loaded    <= 1'b0;
            r_shift_cnt <= '0;
            r_rise_old  <= '0;
            r_fall_new  <= CW'(WIN);
            r_refr      <= '0;
            r_beats     <= '0;
            r_wcnt      <= '0;
            r_peak      <= 1'b0;
            r_bpm       <= '0;
            r_bpm_valid <= 1'b0;
        end else begin
            r_peak      <= 1'b0;
            r_bpm_valid <= 1'b0;
            if (w_accept) begin
                r_loaded <= 1'b1;
                r_prev   <= bus.sample;
                if (r_loaded) begin
                    r_s         <= {r_s[HW-2:0], w_bit};
                    r_rise_old  <= w_rise_nxt;
                    r_fall_new  <= w_fall_nxt;
                    r_shift_cnt <= w_cnt_nxt;
                end
                if (w_detect) begin
                    r_refr <= RW'(REFRACT);
                end else if (r_refr != '0) begin
                    r_refr <= r_refr - RW'(1);
                end
                r_peak <= w_detect;
                if (w_close) begin
                    r_bpm       <= w_bpm_sat;
                    r_bpm_valid <= 1'b1;
                    r_beats     <= '0;
                    r_wcnt      <= '0;
                end else begin
                    r_beats <= w_beats_fin;
                    r_wcnt  <= r_wcnt + WW'(1);
                end
            end
        end
    end

    assign w_s_ext = {8'h00, r_s};

    assign bus.peak_pulse = r_peak;
    assign bus.peak_led   = (r_refr != '0);
    assign bus.bpm        = r_bpm;
    assign bus.bpm_valid  = r_bpm_valid;
    assign bus.slope_dbg  = w_s_ext[7:0];
endmodule

// File: tb/tb_slope_peak_detector.sv
// Random and directed stimulus for slope_peak_detector, checked against a window-popcount model.
// Two instances differ only in BPM_MULT so BPM saturation is exercised alongside normal scaling.
module tb_slope_peak_detector;
    localparam int unsigned DW    = 10;
    localparam int unsigned WIN   = 4;
    localparam int unsigned RISE  = 3;
    localparam int unsigned FALL  = 3;
    localparam int unsigned REFR  = 8;
    localparam int unsigned BW    = 40;
    localparam int unsigned MULT0 = 6;
    localparam int unsigned MULT1 = 100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    slope_peak_detector_if #(.DATA_W(DW)) bus0 ();
    slope_peak_detector_if #(.DATA_W(DW)) bus1 ();

    slope_peak_detector #(
        .DATA_W(DW), .WIN(WIN), .RISE_MIN(RISE), .FALL_MIN(FALL),
        .REFRACT(REFR), .BEAT_WIN(BW), .BPM_MULT(MULT0)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    slope_peak_detector #(
        .DATA_W(DW), .WIN(WIN), .RISE_MIN(RISE), .FALL_MIN(FALL),
        .REFRACT(REFR), .BEAT_WIN(BW), .BPM_MULT(MULT1)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int unsigned n_err = 0;
    int unsigned n_chk = 0;

    // Reference model: full slope history, popcounts recomputed from scratch each sample
    bit          hist[$];
    bit          m_loaded;
    int          m_prev;
    int unsigned m_shifts, m_refr, m_beats, m_wcnt;
    int unsigned m_peak, m_bv;
    int unsigned m_bpm0, m_bpm1;
    int unsigned pulse_cnt;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned sat_bpm(input int unsigned beats, input int unsigned mult);
        int unsigned p;
        p = beats * mult;
        return (p > 255) ? 255 : p;
    endfunction

    function automatic int unsigned model_dbg();
        int unsigned d = 0;
        for (int i = 0; i < 8; i++)
            if (i < hist.size() && hist[i]) d |= (1 << i);
        return d;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_loaded = 0; m_prev = 0; m_shifts = 0; m_refr = 0; m_beats = 0; m_wcnt = 0;
        m_peak = 0; m_bv = 0; m_bpm0 = 0; m_bpm1 = 0;
    endtask

    task automatic model_accept(input int x);
        bit det = 0;
        int unsigned ones_old = 0, zeros_new = 0;
        if (!m_loaded) begin
            m_loaded = 1;
        end else begin
            hist.push_front(x > m_prev);
            if (hist.size() > 2 * WIN) void'(hist.pop_back());
            m_shifts++;
            if (m_shifts >= 2 * WIN) begin
                for (int i = 0; i < WIN; i++) zeros_new += hist[i] ? 0 : 1;
                for (int i = WIN; i < 2 * WIN; i++) ones_old += hist[i] ? 1 : 0;
                det = (ones_old >= RISE) && (zeros_new >= FALL) && (m_refr == 0);
            end
        end
        m_prev = x;
        if (det) m_refr = REFR;
        else if (m_refr > 0) m_refr--;
        if (det && m_beats < 255) m_beats++;
        m_peak = det;
        m_bv = 0;
        m_wcnt++;
        if (m_wcnt == BW) begin
            m_bv = 1;
            m_bpm0 = sat_bpm(m_beats, MULT0);
            m_bpm1 = sat_bpm(m_beats, MULT1);
            m_beats = 0;
            m_wcnt = 0;
        end
    endtask

    task automatic compare_all();
        check("peak_pulse0", 32'(bus0.peak_pulse), m_peak);
        check("peak_led0",   32'(bus0.peak_led),   (m_refr != 0) ? 1 : 0);
        check("bpm0",        32'(bus0.bpm),        m_bpm0);
        check("bpm_valid0",  32'(bus0.bpm_valid),  m_bv);
        check("slope_dbg0",  32'(bus0.slope_dbg),  model_dbg());
        check("peak_pulse1", 32'(bus1.peak_pulse), m_peak);
        check("bpm1",        32'(bus1.bpm),        m_bpm1);
        check("bpm_valid1",  32'(bus1.bpm_valid),  m_bv);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_peak"},  32'(bus0.peak_pulse), 0);
        check({tag, "_led"},   32'(bus0.peak_led),   0);
        check({tag, "_bpm0"},  32'(bus0.bpm),        0);
        check({tag, "_bpm1"},  32'(bus1.bpm),        0);
        check({tag, "_bv"},    32'(bus0.bpm_valid),  0);
        check({tag, "_dbg"},   32'(bus0.slope_dbg),  0);
    endtask

    task automatic step(input bit v, input int x);
        @(negedge clk);
        bus0.sample_valid = v;
        bus0.sample       = DW'(x);
        bus1.sample_valid = v;
        bus1.sample       = DW'(x);
        @(posedge clk);
        #1;
        if (v) model_accept(x);
        else begin
            m_peak = 0;
            m_bv   = 0;
        end
        if (bus0.peak_pulse) pulse_cnt++;
        compare_all();
    endtask

    // Called right after a step: asserts reset between edges and checks outputs clear at once
    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        bus0.sample_valid = 1'b0;
        bus1.sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ramp[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3};
        int pat[10]  = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1};
        int unsigned pulse_at;
        int cur, run, delta;
        bit dir, did_reset;

        bus0.sample_valid = 1'b0; bus0.sample = '0;
        bus1.sample_valid = 1'b0; bus1.sample = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        @(negedge clk);
        reset = 1'b1;

        // Ramp then fall: single peak right after value 5 (index 11) is accepted
        pulse_cnt = 0;
        pulse_at  = 99;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, ramp[i]);
            if (bus0.peak_pulse) pulse_at = i;
        end
        check("ramp_peaks", pulse_cnt, 1);
        check("ramp_peak_at", pulse_at, 11);

        // Flat input
        pulse_cnt = 0;
        for (int i = 0; i < 100; i++) step(1'b1, 512);
        check("flat_peaks", pulse_cnt, 0);
        check("flat_dbg", 32'(bus0.slope_dbg), 0);

        // BPM window: peaks on samples 20, 30 and 40, window closes on sample 40
        mid_reset("rst_a");
        pulse_cnt = 0;
        for (int k = 1; k <= 40; k++) step(1'b1, (k < 12) ? 0 : pat[(k - 12) % 10]);
        check("win_peaks", pulse_cnt, 3);
        check("win_bv", 32'(bus0.bpm_valid), 1);
        check("win_bpm", 32'(bus0.bpm), 18);
        check("win_bpm_sat", 32'(bus1.bpm), 255);
        step(1'b0, 0);
        check("win_bv_drop", 32'(bus0.bpm_valid), 0);
        check("win_bpm_hold", 32'(bus0.bpm), 18);

        // Random up/down runs with idle gaps and one reset mid-window
        cur = 500; run = 0; dir = 1'b0; did_reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit v;
            if (run == 0) begin
                dir = 1'($urandom_range(1, 0));
                run = int'($urandom_range(8, 1));
            end
            v = ($urandom_range(9, 0) < 8);
            if (v) begin
                delta = int'($urandom_range(25, 0));
                cur   = dir ? cur + delta : cur - delta;
                if (cur < 0) cur = 0;
                if (cur > 1023) cur = 1023;
                run--;
            end
            step(v, cur);
            if (!did_reset && n >= 1500 && ((m_beats >= 2 && m_wcnt > 0) || n >= 2500)) begin
                mid_reset("rst_b");
                did_reset = 1'b1;
            end
        end
        check("mid_reset_taken", 32'(did_reset), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
